// File: rtl/kovacs_protocol_sequencer.sv
// kovacs_protocol_sequencer
// N-phase switching sequencer: each phase routes one input channel to the
// DAC path for a programmable number of cycles. It also drives a
// phase-coded indicator for the second DAC.
// Optional build macro: KOVACS_SEQ_ROUND_EN. When defined, width reduction
// rounds half-up with positive saturation. When undefined, it truncates.
//
// Handshake: start_i and stop_i are single-cycle pulses sampled on clk_i.
// stop_i beats start_i, and rst_i beats both. There is no ready signal:
// start_i is accepted only in IDLE and is silently ignored in RUN.
// All outputs are registered from the state held before the edge.
// They therefore lag internal state by one cycle and stay aligned with
// each other. state_o is the unregistered internal state, for debug.
module kovacs_protocol_sequencer #(
    parameter  int N_PHASES = 4,
    parameter  int IN_W     = 16,
    parameter  int OUT_W    = 14,
    parameter  int CNT_W    = 32,
    localparam int PW       = $clog2(N_PHASES)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_PHASES*IN_W-1:0]  data_i,
    input  logic [N_PHASES*CNT_W-1:0] dur_i,
    input  logic [15:0]               n_cycles_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    output logic [OUT_W-1:0]          data_o,
    output logic [OUT_W-1:0]          indicator_o,
    output logic [PW-1:0]             phase_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [15:0]               cycle_count_o,
    output logic                      state_o
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      phase_q, phase_nxt, sel_phase;
    logic [CNT_W-1:0]   cnt_q, dur_q;
    logic [15:0]        ncyc_q, ccount_q;
    logic               done_q, finish;
    logic               phase_end, last_phase, seq_done, go;
    logic [IN_W-1:0]    sel;
    logic [OUT_W-1:0]   red;
    logic [OUT_W-1:0]   data_d, ind_d;
    logic [PW-1:0]      phase_d;
    logic               busy_d;

    assign state_o = state_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a finite run ends at the last phase of the last sequence
    always_comb begin
        phase_end  = (cnt_q == dur_q);
        last_phase = (phase_q == PW'(N_PHASES - 1));
        phase_nxt  = last_phase ? '0 : phase_q + PW'(1);
        seq_done   = (ncyc_q != 16'd0) && (({1'b0, ccount_q} + 17'd1) == {1'b0, ncyc_q});
        go         = start_i && !stop_i;
        finish     = 1'b0;
        state_d    = state_q;
        unique case (state_q)
            IDLE: if (go) state_d = RUN;
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (phase_end && last_phase && seq_done) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Phase/duration/sequence bookkeeping; the duration is latched at phase entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q  <= '0;
            cnt_q    <= '0;
            dur_q    <= '0;
            ncyc_q   <= '0;
            ccount_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= finish;
            if (state_q == IDLE) begin
                if (go) begin
                    phase_q  <= '0;
                    cnt_q    <= '0;
                    dur_q    <= dur_i[0 +: CNT_W];
                    ncyc_q   <= n_cycles_i;
                    ccount_q <= '0;
                end
            end else if (!stop_i) begin
                if (!phase_end) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end else begin
                    cnt_q   <= '0;
                    phase_q <= phase_nxt;
                    dur_q   <= dur_i[int'(phase_nxt)*CNT_W +: CNT_W];
                    if (last_phase && ccount_q != 16'hFFFF) ccount_q <= ccount_q + 16'd1;
                end
            end
        end
    end

    // Channel select: channel 0 passes through while idle
    assign sel_phase = (state_q == RUN) ? phase_q : '0;
    assign sel       = data_i[int'(sel_phase)*IN_W +: IN_W];

    // Width reduction of the selected channel
    generate
        if (OUT_W >= IN_W) begin : g_ext
            assign red = OUT_W'($signed(sel));
        end else begin : g_red
`ifdef KOVACS_SEQ_ROUND_EN
            localparam int SH = IN_W - OUT_W;
            logic [IN_W:0]  ext, sum;
            logic [OUT_W:0] rnd;
            logic           unused_low;
            assign ext        = {sel[IN_W-1], sel};
            assign sum        = ext + ((IN_W + 1)'(1) << (SH - 1));
            assign rnd        = sum[IN_W -: OUT_W + 1];
            assign unused_low = ^sum[SH-1:0];
            // Only a positive input can overflow the half-up add
            assign red = (rnd[OUT_W] != rnd[OUT_W-1]) ? {1'b0, {(OUT_W - 1){1'b1}}}
                                                      : rnd[OUT_W-1:0];
`else
            logic unused_low;
            assign unused_low = ^sel[IN_W-OUT_W-1:0];
            assign red        = sel[IN_W-1 -: OUT_W];
`endif
        end
    endgenerate

    // Output decode from the current (pre-edge) state
    always_comb begin
        data_d  = red;
        ind_d   = '0;
        phase_d = '0;
        busy_d  = 1'b0;
        if (state_q == RUN) begin
            ind_d   = OUT_W'(phase_q) << (OUT_W - 1 - PW);
            phase_d = phase_q;
            busy_d  = 1'b1;
        end
    end

    // Output register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o        <= '0;
            indicator_o   <= '0;
            phase_o       <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            cycle_count_o <= '0;
        end else begin
            data_o        <= data_d;
            indicator_o   <= ind_d;
            phase_o       <= phase_d;
            busy_o        <= busy_d;
            done_o        <= done_q;
            cycle_count_o <= ccount_q;
        end
    end

endmodule

// File: tb/tb_kovacs_protocol_sequencer.sv
// Bench for kovacs_protocol_sequencer (N_PHASES=4, IN_W=16, OUT_W=14).
// The reference model keeps a queue that holds the phase index for each
// cycle of the current phase. The queue is refilled from dur_i whenever a
// phase is entered.
module tb_kovacs_protocol_sequencer;
    localparam int N = 4, IN_W = 16, OUT_W = 14, CNT_W = 32;

    logic clk = 1'b0;
    logic rst, start, stop;
    logic [N*IN_W-1:0]  data;
    logic [N*CNT_W-1:0] dur;
    logic [15:0]        ncyc;
    logic [OUT_W-1:0]   data_o, ind_o;
    logic [1:0]         phase_o;
    logic               busy_o, done_o, state_o;
    logic [15:0]        count_o;

    kovacs_protocol_sequencer #(.N_PHASES(N), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .dur_i(dur), .n_cycles_i(ncyc),
        .start_i(start), .stop_i(stop), .data_o(data_o), .indicator_o(ind_o),
        .phase_o(phase_o), .busy_o(busy_o), .done_o(done_o), .cycle_count_o(count_o),
        .state_o(state_o)
    );

    // Clock
    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    // Model state
    bit m_run = 1'b0, m_done = 1'b0;
    int m_count = 0, m_ncyc = 0;
    int tl[$];
    logic [OUT_W-1:0] e_data, e_ind;
    int e_ph, e_cnt;
    bit e_busy, e_done;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [OUT_W-1:0] red(logic [IN_W-1:0] x);
        int v;
        v = int'($signed(x));
`ifdef KOVACS_SEQ_ROUND_EN
        v = (v + 2) >>> 2;
        if (v > 8191) v = 8191;
`else
        v = v >>> 2;
`endif
        return OUT_W'(v);
    endfunction

    function automatic int dur_of(int k);
        return int'(dur[k*CNT_W +: CNT_W]);
    endfunction

    task automatic push_phase(int k);
        for (int i = 0; i <= dur_of(k); i++) tl.push_back(k);
    endtask

    // Expected outputs after the coming edge, then advance the model
    task automatic model_edge();
        if (m_run) begin
            e_busy = 1'b1;
            e_ph   = tl.pop_front();
            e_cnt  = m_count;
            e_done = 1'b0;
            e_data = red(data[e_ph*IN_W +: IN_W]);
            e_ind  = OUT_W'(e_ph << 11);
            if (stop) begin
                m_run = 1'b0;
                tl.delete();
            end else if (tl.size() == 0) begin
                if (e_ph == N - 1) begin
                    if (m_count < 65535) m_count++;
                    if (m_ncyc != 0 && m_count == m_ncyc) begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                    end
                end
                if (m_run) push_phase((e_ph + 1) % N);
            end
        end else begin
            e_busy = 1'b0;
            e_ph   = 0;
            e_ind  = '0;
            e_cnt  = m_count;
            e_done = m_done;
            m_done = 1'b0;
            e_data = red(data[IN_W-1:0]);
            if (start && !stop) begin
                m_run   = 1'b1;
                m_count = 0;
                m_ncyc  = int'(ncyc);
                push_phase(0);
            end
        end
        if (rst) begin
            e_busy = 1'b0; e_ph = 0; e_ind = '0; e_cnt = 0; e_done = 1'b0; e_data = '0;
            m_run = 1'b0; m_count = 0; m_done = 1'b0;
            tl.delete();
        end
    endtask

    // One clock: predict, advance, compare every output
    task automatic tick(string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".busy"},  32'(busy_o),  32'(e_busy));
        chk({tag, ".phase"}, 32'(phase_o), 32'(e_ph));
        chk({tag, ".ind"},   32'(ind_o),   32'(e_ind));
        chk({tag, ".data"},  32'(data_o),  32'(e_data));
        chk({tag, ".done"},  32'(done_o),  32'(e_done));
        chk({tag, ".count"}, 32'(count_o), 32'(e_cnt));
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) data[k*IN_W +: IN_W] = 16'($urandom);
    endtask

    task automatic set_dur(int a, int b, int c, int d);
        dur = {CNT_W'(d), CNT_W'(c), CNT_W'(b), CNT_W'(a)};
    endtask

    task automatic rand_dur(int hi);
        for (int k = 0; k < N; k++) dur[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, hi));
    endtask

    int bc, dc, runlen;
    bit chg;
    int lens[$];
    logic [OUT_W-1:0] exp_small, exp_neg;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; ncyc = '0; dur = '0;
        rand_data();
        tick("reset");
        rand_data();
        tick("reset");
        rst = 1'b0;
        repeat (3) begin rand_data(); tick("idle"); end

        // Finite run: dur {0,1,2,3}, two sequences
        set_dur(0, 1, 2, 3); ncyc = 16'd2; start = 1'b1;
        tick("fin_start"); start = 1'b0;
        bc = 0; dc = 0;
        repeat (24) begin
            rand_data(); tick("fin");
            bc += int'(busy_o); dc += int'(done_o);
        end
        chk("fin.busy_cycles", 32'(bc), 32'd20);
        chk("fin.done_pulses", 32'(dc), 32'd1);
        chk("fin.final_count", 32'(count_o), 32'd2);

        // Continuous run with random durations, then abort
        rand_dur(4); ncyc = '0; start = 1'b1;
        tick("cont_start"); start = 1'b0;
        repeat (50) begin rand_data(); tick("cont"); end
        stop = 1'b1; tick("stop"); stop = 1'b0;
        tick("stop1");
        chk("stop.busy_off", 32'(busy_o), 32'd0);
        dc = 0;
        repeat (3) begin tick("after_stop"); dc += int'(done_o); end
        chk("stop.no_done", 32'(dc), 32'd0);

        // Simultaneous start and stop from IDLE
        start = 1'b1; stop = 1'b1; tick("ss"); start = 1'b0; stop = 1'b0;
        tick("ss_after");
        chk("ss.stays_idle", 32'(busy_o), 32'd0);

        // Change dur_1 while phase 1 is active
        set_dur(1, 3, 0, 0); ncyc = '0; start = 1'b1;
        tick("dchg_start"); start = 1'b0;
        runlen = 0; chg = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rand_data(); tick("dchg");
            if (busy_o && phase_o == 2'd1) begin
                runlen++;
                if (!chg) begin dur[CNT_W +: CNT_W] = CNT_W'(7); chg = 1'b1; end
            end else if (runlen > 0) begin
                lens.push_back(runlen); runlen = 0;
            end
        end
        while (lens.size() < 2) lens.push_back(0);
        chk("dchg.first_len", 32'(lens[0]), 32'd4);
        chk("dchg.second_len", 32'(lens[1]), 32'd8);
        stop = 1'b1; tick("dchg_stop"); stop = 1'b0;
        tick("dchg_idle");

        // Random runs with occasional stop and ignored start pulses
        repeat (8) begin
            rand_dur(3); ncyc = 16'($urandom_range(0, 3)); start = 1'b1;
            tick("rnd_start"); start = 1'b0;
            repeat ($urandom_range(10, 60)) begin
                rand_data();
                if ($urandom_range(0, 30) == 0) stop = 1'b1;
                if ($urandom_range(0, 15) == 0) start = 1'b1;
                tick("rnd");
                stop = 1'b0; start = 1'b0;
            end
        end
        stop = 1'b1; tick("rnd_stop"); stop = 1'b0;

        // Reset mid-run, then restart at phase 0
        set_dur(2, 2, 2, 2); ncyc = '0; start = 1'b1;
        tick("rm_start"); start = 1'b0;
        repeat (7) begin rand_data(); tick("rm_run"); end
        rst = 1'b1; start = 1'b1; rand_data(); tick("rm_rst"); rst = 1'b0; start = 1'b0;
        chk("rm.busy",  32'(busy_o),  32'd0);
        chk("rm.phase", 32'(phase_o), 32'd0);
        chk("rm.data",  32'(data_o),  32'd0);
        chk("rm.count", 32'(count_o), 32'd0);
        start = 1'b1; tick("rs_start"); start = 1'b0;
        tick("rs_first");
        chk("rs.busy", 32'(busy_o), 32'd1);
        chk("rs.phase0", 32'(phase_o), 32'd0);
        stop = 1'b1; tick("rs_stop"); stop = 1'b0;
        tick("rs_idle");

        // Width-reduction boundaries on the passthrough channel
`ifdef KOVACS_SEQ_ROUND_EN
        exp_small = 14'h0001;
`else
        exp_small = 14'h0000;
`endif
        exp_neg = 14'h2000;
        data[IN_W-1:0] = 16'h7FFF; tick("b7fff");
        chk("b7fff.const", 32'(data_o), 32'h1FFF);
        data[IN_W-1:0] = 16'h0003; tick("b0003");
        chk("b0003.const", 32'(data_o), 32'(exp_small));
        data[IN_W-1:0] = 16'h8000; tick("b8000");
        chk("b8000.const", 32'(data_o), 32'(exp_neg));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/kovacs_protocol_sequencer.md
# kovacs_protocol_sequencer

Parametrised N-phase switching sequencer, successor to the two-state medium/high Kovacs switch. Each phase routes one of N input channels to the DAC path for a per-phase programmable duration. It also drives a phase-coded indicator for the second DAC. It adds start/stop control, a finite or continuous cycle count, and a synchronous reset. It sits between the rescaling stages and the DAC output mux.

## Interface
- `N_PHASES`, 4: number of phases and input channels (2..16).
- `IN_W`, 16: input sample width, two's complement.
- `OUT_W`, 14: output sample width, two's complement.
- `CNT_W`, 32: duration counter width.
- `PW`, $clog2(N_PHASES): phase index width (derived, not overridden).

Ports:
- `clk_i` in 1: sole clock.
- `rst_i` in 1: synchronous, active-high reset.
- `data_i` in N_PHASES*IN_W: channel k occupies bits [k*IN_W +: IN_W].
- `dur_i` in N_PHASES*CNT_W: phase k lasts dur_k+1 cycles.
- `n_cycles_i` in 16: full sequences to run; 0 means run continuously.
- `start_i` in 1: single-cycle start pulse.
- `stop_i` in 1: single-cycle abort pulse.
- `data_o` out OUT_W: selected channel, width-reduced.
- `indicator_o` out OUT_W: phase code, equal to phase << (OUT_W-1-PW).
- `phase_o` out PW: current phase index.
- `busy_o` out 1: high while RUN.
- `done_o` out 1: one-cycle pulse when a finite run completes.
- `cycle_count_o` out 16: completed sequences since start.

## Operation
- Internal states are IDLE and RUN. The internal registers are `phase_q`, `cnt_q`, `dur_q`, `ncyc_q`, and `ccount_q`.
- IDLE to RUN:
  - Trigger: `start_i`=1 and `stop_i`=0.
  - Effects: `phase_q`=0, `cnt_q`=0, `dur_q`=dur_0, `ncyc_q`=`n_cycles_i`, `ccount_q`=0.
- `start_i` is ignored while in RUN.
- RUN, when `cnt_q` != `dur_q`: `cnt_q`++.
- RUN, when `cnt_q` == `dur_q`:
  - Effects: `cnt_q`=0, `phase_q`++, `dur_q` is loaded with the next phase's `dur_i` slice.
  - `dur_i` is sampled only at phase entry. A change mid-phase affects the next entry of that phase.
- End of phase N_PHASES-1:
  - `ccount_q`++ and `phase_q` wraps to 0.
  - If `ncyc_q`!=0 and the incremented count equals `ncyc_q`, go to IDLE and pulse `done_o` for one cycle.
- `stop_i` in RUN:
  - Go to IDLE at the next edge, with no `done_o`.
  - `cycle_count_o` holds its value until the next start.
- `start_i` and `stop_i` together: `stop_i` wins and the state stays or becomes IDLE.
- IDLE outputs:
  - `data_o` passes channel 0 through.
  - `indicator_o`=0, `phase_o`=0, `busy_o`=0.
- Width reduction, default: `data_o` = `data_k`[IN_W-1 -: OUT_W], i.e. truncation. If OUT_W>=IN_W, the input is sign-extended instead.
- `cnt_q` does not wrap. `dur_k`=2^CNT_W-1 is legal and gives 2^CNT_W cycles.
- `ccount_q` saturates at 65535 in continuous mode.

## Timing
- Registered outputs: `data_o`, `indicator_o`, `phase_o`, `busy_o`, `done_o`, `cycle_count_o`. All derive from the state present before the edge, so they lag internal state by exactly 1 cycle and are mutually aligned.
- `data_i` to `data_o` latency is 1 cycle.
- Start latency:
  - `start_i` sampled at edge e0: internal RUN begins after e0.
  - At edge e1: `busy_o`=1, `phase_o`=0.
- Phase k is visible on `phase_o` for exactly dur_k+1 consecutive cycles.
- `done_o` coincides with the first cycle where `busy_o`=0.
- Reset:
  - Every output is 0 and the state is IDLE one edge after `rst_i` is sampled high, including mid-RUN.
  - `rst_i` overrides `start_i` and `stop_i`.

## Configuration
- Macro `KOVACS_SEQ_ROUND_EN`.
  - Defined: width reduction rounds half-up, adding 1<<(IN_W-OUT_W-1) before truncation. The result saturates at 2^(OUT_W-1)-1, so the maximum-positive input does not wrap. Latency is unchanged: the adder and saturation sit in the same register stage.
  - Undefined: plain truncation as in Operation.

## Test plan
- Reset: drive random inputs, assert `rst_i` mid-RUN -> next cycle all outputs 0, `busy_o`=0, and a following `start_i` restarts at phase 0.
- N_PHASES=2, dur={3,5}, `n_cycles_i`=0 -> `phase_o` is 0 for 4 cycles then 1 for 6, with period 10. `indicator_o` is 0 / 4096.
- N_PHASES=4, dur={0,1,2,3}, `n_cycles_i`=2 -> 20 busy cycles, `done_o` pulses once, `cycle_count_o`=2, then IDLE passthrough of channel 0.
- Change dur_1 from 3 to 7 while phase 1 is active -> current phase 1 still lasts 4 cycles, next phase 1 lasts 8.
- Same-cycle `start_i`+`stop_i` from IDLE -> remains IDLE. `stop_i` mid-RUN -> `busy_o`=0 one cycle later, `done_o` never asserted.
- Input 16'h7FFF and 16'h0003 on the active channel:
  - Truncation: 14'h1FFF and 0.
  - With `KOVACS_SEQ_ROUND_EN`: 14'h1FFF (saturated) and 1.
